lsu_mem_bridge: RTL and testbench
=================================

# lsu_mem_bridge

Load/store bridge between the core's data-access port and the word-wide synchronous data memory model `mem`. It accepts one byte, halfword or word request per handshake and performs lane extraction with sign/zero extension on loads. Sub-word stores are done as read-modify-write, because `mem` only writes whole words. It drives `mem`'s `wen_i`, `addr_i` and `data_in_i` ports directly and consumes its `data_out_o`, which is registered with one-cycle read latency.

## Interface
- `MEMSIZE`, default 4096: memory size in bytes; must match the attached `mem` instance and be a multiple of 4.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  bridge can accept; high only in IDLE.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned_i`  in  1  loads only: zero-extend when 1, sign-extend when 0.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid_o`  out  1  response valid; held until accepted.
- `rsp_ready_i`  in  1  requester accepts response.
- `rsp_rdata_o`  out  32  load data, extended; 0 for stores and errors.
- `rsp_err_o`  out  1  misaligned, illegal size, or address ≥ MEMSIZE.
- `mem_wen_o`  out  1  to `mem.wen_i`.
- `mem_addr_o`  out  32  to `mem.addr_i`; always word-aligned (bits [1:0] = 0).
- `mem_wdata_o`  out  32  to `mem.data_in_i`.
- `mem_rdata_i`  in  32  from `mem.data_out_o`.

## Operation
- **Reset values:** state IDLE, `req_ready_o`=1, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `mem_wen_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0.
- **Accept:** a request is accepted at a rising edge where `req_valid_i` and `req_ready_o` are both high. On accept, latch `req_we_i`, `req_size_i`, `req_unsigned_i`, `req_addr_i` and `req_wdata_i`.
- **Error check at accept.** A request is an error if any of these hold:
  - size is 11;
  - a half access has addr[0]=1;
  - a word access has addr[1:0]≠0;
  - addr ≥ MEMSIZE.
  - Error path: go to RESP with `rsp_err_o`=1. No memory access is made.
- **States and transitions:**
  - IDLE → RD for a legal load or a legal sub-word store.
  - IDLE → WR for a legal word store.
  - RD: drive `mem_wen_o`=0 and the word address → LD_CAP for a load, MERGE for a store.
  - LD_CAP: `mem_rdata_i` is valid. Extract the lane selected by addr[1:0] (little-endian), extend it, register it into `rsp_rdata_o` → RESP.
  - MERGE: drive `mem_wen_o`=1. Drive `mem_wdata_o` = `mem_rdata_i` with the addressed byte or half replaced by the latched data → RESP.
  - WR: drive `mem_wen_o`=1 and `mem_wdata_o` = latched data → RESP.
  - RESP: `rsp_valid_o`=1, outputs stable → IDLE on the edge where `rsp_ready_i`=1.
- **Memory port outside RD/MERGE/WR:** `mem_wen_o`=0. `mem_addr_o` holds its last value; ignore it in that case.
- **Ordering:** no overlap. A new request is accepted only after the response handshake completes, so there is at least one IDLE cycle between requests.
- **Reset mid-operation:** return to IDLE on the next edge and drop `rsp_valid_o`.
  - If reset is asserted during MERGE or WR, `mem_wen_o` is still 1 that cycle, but the synchronous reset of `mem` blocks the write. The word stays unchanged.

## Timing
Edge E0 is the accept edge.
- **Legal load:** RD in the cycle after E0, LD_CAP after E1, `rsp_valid_o` high after E2.
- **Word store:** WR after E0, memory written at E1, `rsp_valid_o` high after E1.
- **Sub-word store:** RD after E0, MERGE after E1, memory written at E2, `rsp_valid_o` high after E2.
- **Error:** `rsp_valid_o` high after E0.
- `mem_wen_o` is high for exactly one cycle per store and never high for loads or errors.
- **Back-pressure:** each cycle `rsp_ready_i` stays low extends RESP by one cycle. All `rsp_*` outputs are held constant during that time.

## Structure
- **Package `lsu_mem_pkg`:**
  - size encodings `SZ_B`=2'b00, `SZ_H`=2'b01, `SZ_W`=2'b10;
  - state enum {IDLE, RD, LD_CAP, MERGE, WR, RESP};
  - function `is_misaligned(size, addr[1:0])`.
- **Sub-module `lsu_lane_align`:** combinational. Inputs are the word, addr[1:0], size, unsigned flag and store data. Outputs are the extended load value and the merged store word. It is used by both LD_CAP and MERGE.

## Test plan
- Preload word 0x100 = 0x8899AABB. Signed byte load at 0x101 → `rsp_rdata_o`=0xFFFFFFAA, `rsp_valid_o` high after E2, no `mem_wen_o`.
- Unsigned half load at 0x102 → 0x00008899. Signed half load at 0x102 → 0xFFFF8899.
- Byte store 0x5A at 0x103, then word load at 0x100 → 0x5A99AABB.
  - `mem_wen_o` high exactly one cycle, in MERGE, with `mem_addr_o`=0x100.
- Word load at 0x102, half store at 0x001, load at 0x1000 with MEMSIZE=4096 → each gives `rsp_err_o`=1 after E0, `rsp_rdata_o`=0, `mem_wen_o` never high.
- Word store 0xDEADBEEF at 0x0FFC with `rsp_ready_i` low for 3 cycles:
  - `rsp_valid_o` held 4 cycles and `req_ready_o` low throughout;
  - reload at 0x0FFC → 0xDEADBEEF.
- Assert `rst_n_i`=0 during the MERGE cycle of a byte store to 0x100 → next state IDLE, `rsp_valid_o`=0, word 0x100 unchanged.

Source files
------------

// File: rtl/lsu_mem_pkg.sv
// Shared types for the load/store memory bridge.
// Size encodings, FSM states and the alignment helper.
package lsu_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LD_CAP,
    MERGE,
    WR,
    RESP
  } state_e;

  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic r;
    r = 1'b0;
    if (size == SZ_H) r = a[0];
    if (size == SZ_W) r = |a;
    return r;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extract/extend for loads and lane merge for stores.
// Ports: word, off, size, is_unsigned, st_data in; ld_data, st_word out.
module lsu_lane_align
  import lsu_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [31:0] bshift;
  logic [31:0] hshift;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    bsh     = {off, 3'b000};
    hsh     = {off[1], 4'b0000};
    bshift  = word >> bsh;
    hshift  = word >> hsh;
    b       = bshift[7:0];
    h       = hshift[15:0];
    ld_data = word;
    st_word = st_data;
    unique case (size)
      SZ_B: begin
        ld_data = {{24{~is_unsigned & b[7]}}, b};
        st_word = (word & ~(32'h0000_00ff << bsh))
                | ({24'b0, st_data[7:0]} << bsh);
      end
      SZ_H: begin
        ld_data = {{16{~is_unsigned & h[15]}}, h};
        st_word = (word & ~(32'h0000_ffff << hsh))
                | ({16'b0, st_data[15:0]} << hsh);
      end
      default: begin
        ld_data = word;
        st_word = st_data;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// LSU to word-wide synchronous memory bridge (RMW for sub-word stores).
// Ports: clk_i, rst_n_i, req_*, rsp_*, mem_* (wen/addr/wdata out, rdata in).
module lsu_mem_bridge
  import lsu_mem_pkg::*;
#(
  parameter int MEMSIZE = 4096
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEMSIZE);

  state_e      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic        accept;
  logic        req_err;

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign accept      = req_valid_i & req_ready_o;

  assign req_err = (req_size_i == 2'b11)
                 | is_misaligned(req_size_i, req_addr_i[1:0])
                 | ({1'b0, req_addr_i} >= MEM_LIMIT);

  // Merged word must follow the live read data during MERGE.
  assign mem_wdata_o = (state == MERGE) ? st_word : mem_wdata_q;

  lsu_lane_align u_align (
    .word        (mem_rdata_i),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .st_data     (wdata_q),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= SZ_B;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      mem_wdata_q <= '0;
      mem_wen_o   <= 1'b0;
      mem_addr_o  <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            we_q        <= req_we_i;
            uns_q       <= req_unsigned_i;
            size_q      <= req_size_i;
            off_q       <= req_addr_i[1:0];
            wdata_q     <= req_wdata_i;
            rsp_rdata_o <= '0;
            rsp_err_o   <= req_err;
            if (req_err) begin
              state <= RESP;
            end else begin
              mem_addr_o <= {req_addr_i[31:2], 2'b00};
              if (req_we_i && req_size_i == SZ_W) begin
                state       <= WR;
                mem_wen_o   <= 1'b1;
                mem_wdata_q <= req_wdata_i;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          if (we_q) begin
            state     <= MERGE;
            mem_wen_o <= 1'b1;
          end else begin
            state <= LD_CAP;
          end
        end
        LD_CAP: begin
          rsp_rdata_o <= ld_data;
          state       <= RESP;
        end
        MERGE: begin
          mem_wen_o   <= 1'b0;
          mem_wdata_q <= st_word;
          state       <= RESP;
        end
        WR: begin
          mem_wen_o <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Testbench for lsu_mem_bridge with a word-wide synchronous memory model.
// Table-driven transactions plus back-pressure and mid-store reset cases.
module tb_lsu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem_arr [0:1023];
  int          wen_cnt;
  logic [31:0] wen_addr;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  lsu_mem_bridge #(.MEMSIZE(4096)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .mem_wen_o      (mem_wen),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  // Memory model: registered read, whole-word write, reset blocks writes.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem_rdata <= '0;
    end else begin
      if (mem_wen) mem_arr[mem_addr[11:2]] <= mem_wdata;
      mem_rdata <= mem_arr[mem_addr[11:2]];
    end
  end

  always @(posedge clk) begin
    if (mem_wen) begin
      wen_cnt  = wen_cnt + 1;
      wen_addr = mem_addr;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wen;
    int          hold;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total = total + 1;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed = passed + 1;
  endtask

  task automatic txn(input vec_t v, input string tag);
    int lat;
    logic [31:0] rd0;
    logic err0;
    req_we    = v.we;
    req_size  = v.size;
    req_uns   = v.uns;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    wen_cnt   = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, " err"}, {31'b0, rsp_err}, {31'b0, v.exp_err});
    chk({tag, " ready_in_resp"}, {31'b0, req_ready}, 32'd0);
    chk({tag, " wen_count"}, 32'(wen_cnt), 32'(v.exp_wen));
    if (v.exp_wen != 0)
      chk({tag, " wen_addr"}, wen_addr, {v.addr[31:2], 2'b00});
    rd0  = rsp_rdata;
    err0 = rsp_err;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " held_valid"}, {31'b0, rsp_valid}, 32'd1);
      chk({tag, " held_ready"}, {31'b0, req_ready}, 32'd0);
      chk({tag, " held_rdata"}, rsp_rdata, rd0);
      chk({tag, " held_err"}, {31'b0, rsp_err}, {31'b0, err0});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, " valid_drop"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] sz,
      input logic u, input logic [31:0] a, input logic [31:0] wd,
      input logic [31:0] er, input logic ee, input int lat,
      input int wn, input int hd);
    vec_t v;
    v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
    v.exp_wen = wn; v.hold = hd;
    return v;
  endfunction

  initial begin
    vec_t v;
    for (int i = 0; i < 1024; i++) mem_arr[i] = '0;
    mem_arr[32'h100 >> 2] = 32'h8899AABB;

    vecs[0]  = mk(0, 2'b00, 0, 32'h101, 0, 32'hFFFFFFAA, 0, 2, 0, 0);
    vecs[1]  = mk(0, 2'b01, 1, 32'h102, 0, 32'h00008899, 0, 2, 0, 0);
    vecs[2]  = mk(0, 2'b01, 0, 32'h102, 0, 32'hFFFF8899, 0, 2, 0, 0);
    vecs[3]  = mk(1, 2'b00, 0, 32'h103, 32'h5A, 0, 0, 2, 1, 0);
    vecs[4]  = mk(0, 2'b10, 0, 32'h100, 0, 32'h5A99AABB, 0, 2, 0, 0);
    vecs[5]  = mk(0, 2'b10, 0, 32'h102, 0, 0, 1, 0, 0, 0);
    vecs[6]  = mk(1, 2'b01, 0, 32'h001, 32'h1234, 0, 1, 0, 0, 0);
    vecs[7]  = mk(0, 2'b00, 0, 32'h1000, 0, 0, 1, 0, 0, 0);
    vecs[8]  = mk(0, 2'b11, 0, 32'h100, 0, 0, 1, 0, 0, 0);
    vecs[9]  = mk(1, 2'b01, 0, 32'h102, 32'h1234BEEF, 0, 0, 2, 1, 0);
    vecs[10] = mk(0, 2'b00, 1, 32'h100, 0, 32'h000000BB, 0, 2, 0, 0);
    vecs[11] = mk(0, 2'b00, 0, 32'h103, 0, 32'hFFFFFFBE, 0, 2, 0, 0);
    vecs[12] = mk(1, 2'b10, 0, 32'hFFC, 32'hDEADBEEF, 0, 0, 1, 1, 3);
    vecs[13] = mk(0, 2'b10, 0, 32'hFFC, 0, 32'hDEADBEEF, 0, 2, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst mem_wen", {31'b0, mem_wen}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) txn(vecs[i], $sformatf("v%0d", i));

    // Reset during the MERGE cycle of a byte store to 0x100.
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_uns   = 1'b0;
    req_addr  = 32'h100;
    req_wdata = 32'h11;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid wen_in_merge", {31'b0, mem_wen}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid req_ready", {31'b0, req_ready}, 32'd1);
    chk("rstmid rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rstmid mem_wen", {31'b0, mem_wen}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = mk(0, 2'b10, 0, 32'h100, 0, 32'hBEEFAABB, 0, 2, 0, 0);
    txn(v, "rstmid reload");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
